// File: rtl/weighting_matrix_tc_sequencer_if.sv
// Valid/ready stream bundle used for every stream port of weighting_matrix_tc_sequencer.
interface weighting_matrix_tc_sequencer_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/weighting_matrix_tc_sequencer.sv
// Run sequencer in front of weighting_matrix_tc_axi_wrapper: TC load, then pixels, W forwarded to DMA.
// Optional start-to-done cycle counter is built only when WMTC_SEQ_PERF_EN is defined.
module weighting_matrix_tc_sequencer #(
  parameter int WIDTH               = 32,
  parameter int NUM_PIXELS          = 4096,
  parameter int NUM_CHANNELS        = 128,
  parameter int NUM_SIGNATURES      = 15,
  parameter int NUM_OUTPUT_CHANNELS = 3,
  parameter int PERF_WIDTH          = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_last_o,
  weighting_matrix_tc_sequencer_if.slave  s_axis,
  weighting_matrix_tc_sequencer_if.master tc,
  weighting_matrix_tc_sequencer_if.master p,
  weighting_matrix_tc_sequencer_if.slave  w,
  weighting_matrix_tc_sequencer_if.master m_axis,
  input  logic                            finished_loading_i,
  input  logic                            finished_i,
  output logic [PERF_WIDTH-1:0]           perf_cycles_o
);

  localparam int TC_BEATS = NUM_CHANNELS * NUM_SIGNATURES;
  localparam int P_BEATS  = NUM_PIXELS * NUM_CHANNELS;
  localparam int W_BEATS  = NUM_CHANNELS * NUM_OUTPUT_CHANNELS;
  localparam int TCW      = $clog2(TC_BEATS) + 1;
  localparam int PW       = $clog2(P_BEATS) + 1;
  localparam int WW       = $clog2(W_BEATS) + 1;

  localparam logic [TCW-1:0] TC_LAST = TCW'(TC_BEATS - 1);
  localparam logic [PW-1:0]  P_LAST  = PW'(P_BEATS - 1);
  localparam logic [WW-1:0]  W_LAST  = WW'(W_BEATS - 1);
  localparam logic [WW-1:0]  W_END   = WW'(W_BEATS);

  typedef enum logic [2:0] {IDLE, LOAD_TC, WAIT_LOADED, STREAM_P, DRAIN_W, DONE} state_t;

  state_t         state_q, state_d;
  logic [TCW-1:0] tc_cnt_q, tc_cnt_d;
  logic [PW-1:0]  p_cnt_q, p_cnt_d;
  logic [WW-1:0]  w_cnt_q, w_cnt_d;
  logic           err_q, err_d;
  logic           fin_q, fin_d;
  logic           tc_last, w_active, w_hs, w_done;
  logic           unused_w_last;

  assign unused_w_last = w.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tc_cnt_q <= '0;
      p_cnt_q  <= '0;
      w_cnt_q  <= '0;
      err_q    <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tc_cnt_q <= tc_cnt_d;
      p_cnt_q  <= p_cnt_d;
      w_cnt_q  <= w_cnt_d;
      err_q    <= err_d;
      fin_q    <= fin_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tc_cnt_d     = tc_cnt_q;
    p_cnt_d      = p_cnt_q;
    w_cnt_d      = w_cnt_q;
    err_d        = err_q;
    fin_d        = fin_q;
    s_axis.ready = 1'b0;
    tc.valid     = 1'b0;
    tc.data      = s_axis.data;
    tc.last      = 1'b0;
    p.valid      = 1'b0;
    p.data       = s_axis.data;
    p.last       = 1'b0;
    w.ready      = 1'b0;
    m_axis.valid = 1'b0;
    m_axis.data  = w.data;
    m_axis.last  = 1'b0;

    tc_last  = (tc_cnt_q == TC_LAST);
    // W forwarding closes once the full W frame has gone out, so the counter never wraps.
    w_active = ((state_q == STREAM_P) || (state_q == DRAIN_W)) && (w_cnt_q != W_END);
    w_hs     = w_active && w.valid && m_axis.ready;
    w_done   = (w_cnt_q == W_END) || (w_hs && (w_cnt_q == W_LAST));

    if (w_active) begin
      m_axis.valid = w.valid;
      w.ready      = m_axis.ready;
      m_axis.last  = (w_cnt_q == W_LAST);
    end
    if (w_hs) w_cnt_d = w_cnt_q + WW'(1);

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = LOAD_TC;
          tc_cnt_d = '0;
          p_cnt_d  = '0;
          w_cnt_d  = '0;
          err_d    = 1'b0;
          fin_d    = 1'b0;
        end
      end
      LOAD_TC: begin
        tc.valid     = s_axis.valid;
        s_axis.ready = tc.ready;
        tc.last      = tc_last;
        if (s_axis.valid && tc.ready) begin
          tc_cnt_d = tc_cnt_q + TCW'(1);
          if (s_axis.last != tc_last) err_d = 1'b1;
          if (tc_last) state_d = WAIT_LOADED;
        end
      end
      WAIT_LOADED: begin
        if (finished_loading_i) state_d = STREAM_P;
      end
      STREAM_P: begin
        p.valid      = s_axis.valid;
        s_axis.ready = p.ready;
        if (finished_i) fin_d = 1'b1;
        if (s_axis.valid && p.ready) begin
          p_cnt_d = p_cnt_q + PW'(1);
          if (p_cnt_q == P_LAST) state_d = DRAIN_W;
        end
      end
      DRAIN_W: begin
        if (finished_i) fin_d = 1'b1;
        if ((fin_q || finished_i) && w_done) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign err_last_o = err_q;

`ifdef WMTC_SEQ_PERF_EN
  logic [PERF_WIDTH-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == IDLE) && start_i) perf_d = '0;
    else if ((state_q != IDLE) && (perf_q != '1)) perf_d = perf_q + PERF_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule

// File: doc/weighting_matrix_tc_sequencer.md
Name: weighting_matrix_tc_sequencer

Overview:
Run controller in front of weighting_matrix_tc_axi_wrapper. Takes one DMA input AXI-stream and demultiplexes it in order: first the TC load stream, then the pixel stream. Forwards the W result stream to a DMA write channel with its own beat counting and `last` generation. Exposes start/busy/done/error to the host register block.

Parameters:
WIDTH, 32, scalar/data width of all streams
NUM_PIXELS, 4096, pixels per image
NUM_CHANNELS, 128, spectral channels
NUM_SIGNATURES, 15, signatures; TC beats = NUM_CHANNELS*NUM_SIGNATURES
NUM_OUTPUT_CHANNELS, 3, output channels; W beats = NUM_CHANNELS*NUM_OUTPUT_CHANNELS
PERF_WIDTH, 32, width of cycle counter (optional feature)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle run request; honoured only in IDLE
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on entry to DONE
err_last  out  1  sticky: s_axis_last mismatch during TC load; cleared by start or rst
s_axis_data/valid/ready/last  in/in/out/in  WIDTH/1/1/1  DMA input stream
tc_data/valid/ready/last  out/out/in/out  WIDTH/1/1/1  to wrapper axis_tc_load_*
p_data/valid/ready  out/out/in  WIDTH/1/1  to wrapper axis_p_*
finished_loading, finished  in  1 each  status from wrapper
w_data/valid/ready  in/in/out  WIDTH/1/1  from wrapper axis_w_*; w_last input is ignored
m_axis_data/valid/ready/last  out/out/in/out  WIDTH/1/1/1  to DMA write channel
perf_cycles  out  PERF_WIDTH  cycles from start to done

Behaviour:
- Reset values: state=IDLE, all counters 0, busy=0, done=0, err_last=0, perf_cycles=0, all valid/ready outputs 0.
- FSM states: IDLE, LOAD_TC, WAIT_LOADED, STREAM_P, DRAIN_W, DONE.
- IDLE: start -> LOAD_TC. Clears counters and err_last.
- LOAD_TC: tc_valid=s_axis_valid, s_axis_ready=tc_ready, tc_data=s_axis_data, all combinational with zero latency.
  - tc_last is generated from the counter: 1 when tc_cnt==TC_BEATS-1.
  - Each tc handshake increments tc_cnt.
  - On any beat where s_axis_last != generated tc_last, set err_last. The beat is still forwarded.
  - Final beat accepted -> WAIT_LOADED.
- WAIT_LOADED: s_axis_ready=0. finished_loading=1 -> STREAM_P.
- STREAM_P: p_valid=s_axis_valid, s_axis_ready=p_ready. p_cnt counts handshakes up to NUM_PIXELS*NUM_CHANNELS. s_axis_last is ignored. Final beat -> DRAIN_W.
- W forwarding is active in STREAM_P and DRAIN_W:
  - m_axis_valid=w_valid, w_ready=m_axis_ready.
  - m_axis_last=1 when w_cnt==W_BEATS-1.
  - w_ready=0 in all other states.
- DRAIN_W: leave only when both flags are set: (a) the last W beat has been accepted, and (b) finished has been seen. finished is latched sticky from the start of STREAM_P. -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Simultaneous final-P beat and final-W beat in the same cycle: both are counted.
- start while busy: ignored.
- rst mid-run: immediate return to IDLE and all outputs to reset values. No draining. Upstream DMA and the wrapper must be reset alongside.
- Counter widths: $clog2(max beats)+1. Counters stop at their terminal value; they do not wrap.

Optional Feature:
WMTC_SEQ_PERF_EN
- Defined: perf_cycles clears on start and increments every busy cycle, saturating at all-ones. It holds its value after done until the next start.
- Undefined: perf_cycles is tied to 0 and no counter logic is generated.

Test Plan:
Params for all scenarios: PIXELS=4, CHANNELS=4, SIGNATURES=2, OUTPUT_CHANNELS=2. This gives TC=8, P=16, W=8 beats.
1. start, 8 TC beats with last on beat 8, finished_loading after 3 cycles, 16 P beats, 8 W beats, finished -> tc_last only on beat 8; m_axis_last only on W beat 8; exactly one done pulse; err_last=0.
2. s_axis_last asserted on TC beat 5 -> err_last=1 from beat 5 onward; run still completes with done; next start clears err_last.
3. Random valid/ready backpressure (50%) on every stream -> no beat lost or duplicated; output data order equals input order.
4. finished asserted before the last W beat -> done only after the last W handshake. Also: last W beat accepted before finished -> done only 1 cycle after finished.
5. rst asserted mid STREAM_P at p_cnt=7 -> next cycle busy=0, all valid/ready outputs 0; a fresh start runs cleanly.
6. WMTC_SEQ_PERF_EN defined, scenario 1 run -> perf_cycles equals the number of busy cycles measured by the bench. Undefined -> perf_cycles stays 0.
